// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit common-anode 7-segment scan driver with per-frame value capture.
// Optional SEG_LZ_BLANK_EN: leading-zero blanking of digits 1..3.
module seg_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GAP_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [0:0]    phase;
  logic [15:0]   shadow;
  logic [3:0]    dp_shadow;

  logic wrap;
  logic gap_end;
  logic capture;
  logic supp;
  logic drive;

  assign wrap    = (cnt == CNT_LAST);
  assign gap_end = (cnt == GAP_LAST);
  assign capture = (idx == 2'd0) && (phase == BLANK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      idx         <= 2'd0;
      phase       <= BLANK;
      shadow      <= 16'h0000;
      dp_shadow   <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) begin
        idx <= idx + 2'd1;
      end
      unique case (1'b1)
        wrap:    phase <= BLANK;
        gap_end: phase <= DRIVE;
        default: phase <= phase;
      endcase
      // Sampling through the whole digit-0 gap keeps the last sample.
      if (capture) begin
        shadow    <= value;
        dp_shadow <= dp_in;
      end
      frame_start <= wrap && (idx == 2'd3);
    end
  end

  always_comb begin
    digit = 4'h0;
    unique case (idx)
      2'd0: digit = shadow[3:0];
      2'd1: digit = shadow[7:4];
      2'd2: digit = shadow[11:8];
      2'd3: digit = shadow[15:12];
      default: digit = 4'h0;
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  always_comb begin
    supp = 1'b0;
    unique case (idx)
      2'd0: supp = 1'b0;
      2'd1: supp = (shadow[15:4] == 12'h000);
      2'd2: supp = (shadow[15:8] == 8'h00);
      2'd3: supp = (shadow[15:12] == 4'h0);
      default: supp = 1'b0;
    endcase
  end
`else
  assign supp = 1'b0;
`endif

  assign drive = (phase == DRIVE) && en && !supp;

  always_comb begin
    an = 4'hF;
    dp = 1'b1;
    if (drive) begin
      an = ~(4'b0001 << idx);
      dp = ~dp_shadow[idx];
    end
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scan driver for the 4-digit common-anode 7-segment display. It takes a 16-bit hex value and per-digit decimal points, and walks the four digits in turn. For each digit it drives one active-low anode enable and presents that digit's nibble to the downstream hex-to-7-segment decoder. A blanking gap at the start of every digit slot suppresses ghosting. The displayed value is captured once per frame so a digit never tears mid-frame.

## Interface
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2
- GAP_CYCLES, 1000, blank cycles at the start of each slot; 1 ≤ GAP_CYCLES < REFRESH_DIV
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous, active-low reset
- en  input  1  display enable; 0 forces all anodes off
- value  input  16  four hex digits; [3:0] is digit 0 (rightmost)
- dp_in  input  4  decimal-point request per digit, active-high; bit i is digit i
- digit  output  4  nibble of the currently scanned digit, to the decoder input
- an  output  4  anode enables, active-low, one-hot-low while driving
- dp  output  1  decimal-point segment, active-low
- frame_start  output  1  one-cycle pulse on the first cycle of digit 0's slot

## Operation
- State registers:
  - cnt, slot counter 0..REFRESH_DIV-1
  - idx, digit index 0..3
  - phase: BLANK or DRIVE
  - shadow, 16 bits
  - dp_shadow, 4 bits
- Reset state: cnt=0, idx=0, phase=BLANK, shadow=0, dp_shadow=0.
- Reset values of the outputs: an=4'b1111, digit=0, dp=1, frame_start=0.
- Each cycle cnt increments. At cnt==REFRESH_DIV-1, cnt wraps to 0 and idx advances mod 4 (3→0).
- phase is BLANK while cnt < GAP_CYCLES and DRIVE otherwise. Transitions:
  - BLANK→DRIVE on the edge where cnt goes GAP_CYCLES-1 → GAP_CYCLES.
  - DRIVE→BLANK on the slot wrap.
- Shadow capture: shadow←value and dp_shadow←dp_in on every cycle with idx==0 and phase==BLANK. They are frozen for the rest of the frame, so the last sample taken is the one from the final BLANK cycle of digit 0.
- Outputs (Moore, decoded from registers):
  - digit = shadow[4*idx+3 : 4*idx] at all times.
  - an = ~(4'b0001 << idx) when phase==DRIVE and en==1 and the digit is not suppressed; otherwise 4'b1111.
  - dp = ~dp_shadow[idx] whenever an is not 4'b1111; otherwise 1.
  - frame_start = 1 iff idx==0 and cnt==0, excluding the reset cycle itself.
- en is combinational onto an/dp only. It does not stop cnt, idx or shadow capture.
- Reset asserted mid-slot: on the next edge all state returns to reset values, and an goes to 4'b1111 in that same cycle.

## Timing
- Cycle 0 is the first edge with reset_n=1.
  - cycles 0..GAP_CYCLES-1: an=1111 (digit 0 blank gap)
  - cycle GAP_CYCLES: an=1110 for digit 0
  - cycle REFRESH_DIV: slot 1 blank gap begins
- Frame period is 4·REFRESH_DIV cycles.
- frame_start pulses at cycles 4k·REFRESH_DIV for k≥1.
- Latency from value change to display is at most one frame plus GAP_CYCLES.
- A value change during DRIVE of any digit, or during the BLANK of digits 1–3, is not shown until the next frame.
- No two anodes are ever low in the same cycle. Between any two driven digits, all anodes are high for at least GAP_CYCLES cycles.

## Configuration
- SEG_LZ_BLANK_EN, defined: leading-zero blanking.
  - Digit i (i≥1) is suppressed when shadow bits [15 : 4i] are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps an=1111 and dp=1 for its whole slot, even if its dp_shadow bit is set.
  - Timing, cnt/idx sequencing and digit output are unchanged.
- SEG_LZ_BLANK_EN, undefined: no digit is ever suppressed. All four digits are driven every frame, including leading zeros.

## Test plan
Bench settings: REFRESH_DIV=8, GAP_CYCLES=2.
- Reset scan: hold reset_n=0 for 3 cycles, then release with value=16'h1234, en=1, dp_in=0.
  - an=1111 at cycles 0–1, 1110 at cycles 2–7, 1111 at cycles 8–9, 1101 at cycles 10–15, and so on.
  - digit = 4, 3, 2, 1 across the four slots; frame_start high at cycle 32.
- Frame coherency: change value 16'h1234→16'hABCD at cycle 12.
  - Frame 0 still shows 4, 3, 2, 1.
  - Frame 1 (cycles 32–63) shows D, C, B, A.
- Decimal point and enable: dp_in=4'b0100.
  - dp=0 only during DRIVE of digit 2 (cycles 18–23).
  - Dropping en=0 during cycle 20 gives an=1111 and dp=1 in that cycle, while cnt/idx keep advancing.
- Mid-slot reset: assert reset_n=0 at cycle 13.
  - an=1111, digit=0, dp=1 from the next cycle.
  - After release, the sequence restarts exactly as in the reset scan case.
- Leading-zero blanking: value=16'h0050.
  - With SEG_LZ_BLANK_EN defined: digits 3 and 2 keep an=1111 for their whole slots; digits 1 and 0 are driven (5, 0).
  - Without it: all four digits are driven, showing 0, 5, 0, 0.
- Simultaneous events: a value change on the final BLANK cycle of digit 0 (cycle 1) is captured and shown in that same frame.
